alu_accum_unit: RTL and testbench

- Parametrised successor to the switch-driven ADD/SUB/MUL operator block.
- Takes two HALF-width operands plus an opcode over a valid/ready input handshake, computes the result, and returns a full-width result over a valid/ready output handshake.
- Adds an internal accumulator (multiply-accumulate, MAC), an iterative shift-add multiplier, a sticky overflow flag, and output backpressure.
- Sits between the switch/selector front-end and the LED/display driver.

---
 rtl/alu_accum_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_accum_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_unit.sv
// ADD/SUB/MUL/MAC operator block with accumulator, sticky overflow and valid/ready handshakes.
// Define ALU_FAST_MUL_EN for a single-cycle multiplier; the default build uses an iterative shift-add.
module alu_accum_unit #(
  parameter int W     = 16,
  parameter int HALF  = W / 2,
  parameter int CNT_W = $clog2(HALF) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  output logic [W-1:0]    res,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            ovf,
  output logic            err
);

  localparam logic [2:0] OP_CLR   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_MAC   = 3'd4;
  localparam logic [2:0] OP_RDACC = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sum with carry-out; the carry is the MAC overflow indication.
  function automatic logic [W:0] add_carry(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  state_t         state_r, state_nxt;
  logic [W-1:0]   res_r, res_nxt;
  logic           res_valid_r, res_valid_nxt;
  logic           in_ready_r, in_ready_nxt;
  logic [W-1:0]   acc_r, acc_nxt;
  logic           ovf_r, ovf_nxt;
  logic           err_r, err_nxt;

  logic [W-1:0]   a_ext_s;
  logic [W-1:0]   b_ext_s;
  logic [W-1:0]   mul_prod_s;
  logic [W:0]     mac_sum_s;

  assign a_ext_s = {{(W-HALF){1'b0}}, a};
  assign b_ext_s = {{(W-HALF){1'b0}}, b};

`ifdef ALU_FAST_MUL_EN
  assign mul_prod_s = a_ext_s * b_ext_s;
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [2:0]      op_r, op_nxt;
  logic [W-1:0]    mcand_r, mcand_nxt;
  logic [HALF-1:0] mplier_r, mplier_nxt;
  logic [W-1:0]    prod_r, prod_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [W-1:0]    step_s;

  // One shift-add step: partial product plus the shifted multiplicand when the current bit is set.
  assign step_s     = prod_r + (mplier_r[0] ? mcand_r : {W{1'b0}});
  assign mul_prod_s = step_s;
`endif

  assign mac_sum_s = add_carry(acc_r, mul_prod_s);

  // Next-state and next-output logic for the IDLE/MULT/DONE controller.
  always_comb begin
    state_nxt     = state_r;
    res_nxt       = res_r;
    res_valid_nxt = res_valid_r;
    in_ready_nxt  = in_ready_r;
    acc_nxt       = acc_r;
    ovf_nxt       = ovf_r;
    err_nxt       = err_r;
`ifndef ALU_FAST_MUL_EN
    op_nxt        = op_r;
    mcand_nxt     = mcand_r;
    mplier_nxt    = mplier_r;
    prod_nxt      = prod_r;
    cnt_nxt       = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          in_ready_nxt  = 1'b0;
          err_nxt       = 1'b0;
          state_nxt     = DONE;
          res_valid_nxt = 1'b1;
          case (op)
            OP_CLR: begin
              res_nxt = {W{1'b0}};
              acc_nxt = {W{1'b0}};
              ovf_nxt = 1'b0;
            end
            OP_ADD:   res_nxt = a_ext_s + b_ext_s;
            OP_SUB:   res_nxt = a_ext_s - b_ext_s;
            OP_RDACC: res_nxt = acc_r;
`ifdef ALU_FAST_MUL_EN
            OP_MUL:   res_nxt = mul_prod_s;
            OP_MAC: begin
              res_nxt = mac_sum_s[W-1:0];
              acc_nxt = mac_sum_s[W-1:0];
              ovf_nxt = ovf_r | mac_sum_s[W];
            end
`else
            OP_MUL, OP_MAC: begin
              state_nxt     = MULT;
              res_valid_nxt = 1'b0;
              op_nxt        = op;
              mcand_nxt     = a_ext_s;
              mplier_nxt    = b;
              prod_nxt      = {W{1'b0}};
              cnt_nxt       = {CNT_W{1'b0}};
            end
`endif
            default: begin
              res_nxt = {W{1'b0}};
              err_nxt = 1'b1;
            end
          endcase
        end else begin
          in_ready_nxt = 1'b1;
        end
      end
`ifdef ALU_FAST_MUL_EN
      MULT: begin
        state_nxt    = IDLE;
        in_ready_nxt = 1'b1;
      end
`else
      MULT: begin
        prod_nxt   = step_s;
        mcand_nxt  = {mcand_r[W-2:0], 1'b0};
        mplier_nxt = {1'b0, mplier_r[HALF-1:1]};
        cnt_nxt    = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          state_nxt     = DONE;
          res_valid_nxt = 1'b1;
          if (op_r == OP_MAC) begin
            res_nxt = mac_sum_s[W-1:0];
            acc_nxt = mac_sum_s[W-1:0];
            ovf_nxt = ovf_r | mac_sum_s[W];
          end else begin
            res_nxt = step_s;
          end
        end else begin
          state_nxt = MULT;
        end
      end
`endif
      DONE: begin
        if (res_ready) begin
          state_nxt     = IDLE;
          res_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end else begin
          state_nxt     = DONE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        res_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b1;
      end
    endcase
  end

  // Controller, result and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      res_r       <= {W{1'b0}};
      res_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      acc_r       <= {W{1'b0}};
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      res_r       <= res_nxt;
      res_valid_r <= res_valid_nxt;
      in_ready_r  <= in_ready_nxt;
      acc_r       <= acc_nxt;
      ovf_r       <= ovf_nxt;
      err_r       <= err_nxt;
    end
  end

`ifndef ALU_FAST_MUL_EN
  // Iterative multiplier datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 3'd0;
      mcand_r  <= {W{1'b0}};
      mplier_r <= {HALF{1'b0}};
      prod_r   <= {W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      op_r     <= op_nxt;
      mcand_r  <= mcand_nxt;
      mplier_r <= mplier_nxt;
      prod_r   <= prod_nxt;
      cnt_r    <= cnt_nxt;
    end
  end
`endif

  assign res       = res_r;
  assign res_valid = res_valid_r;
  assign in_ready  = in_ready_r;
  assign ovf       = ovf_r;
  assign err       = err_r;

endmodule

// File: tb/tb_alu_accum_unit.sv
// Directed-vector bench for alu_accum_unit at W=16.
module tb_alu_accum_unit;

  localparam int W = 16;
  localparam int HALF = 8;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = HALF;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [HALF-1:0] a;
  logic [HALF-1:0] b;
  logic [W-1:0]    res;
  logic            res_valid;
  logic            res_ready;
  logic            ovf;
  logic            err;

  int vectors = 0;
  int miscompares = 0;

  alu_accum_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .res(res), .res_valid(res_valid),
    .res_ready(res_ready), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Issues one request from IDLE; k = extra edges after acceptance until res_valid (50 = timed out).
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] r, output int k);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    r = res;
    if (res_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({res, res_valid, in_ready, ovf, err} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: res=%h v=%b rdy=%b ovf=%b err=%b, want 0000 0 1 0 0",
               res, res_valid, in_ready, ovf, err);
    end
  endtask

  task automatic test_add();
    logic [15:0] r; int k;
    do_op(3'd1, 8'h12, 8'h34, r, k);
    vectors++;
    if (r !== 16'h0046) begin miscompares++; $display("FAIL add_res: got %h want 0046", r); end
    vectors++;
    if (k !== 0) begin miscompares++; $display("FAIL add_latency: got %0d want 0", k); end
    vectors++;
    if ({in_ready, res_valid} !== 2'b10) begin
      miscompares++; $display("FAIL add_release: rdy/v=%b%b want 10", in_ready, res_valid);
    end
  endtask

  task automatic test_sub();
    logic [15:0] r; int k;
    do_op(3'd2, 8'h05, 8'h07, r, k);
    vectors++;
    if (r !== 16'hFFFE) begin miscompares++; $display("FAIL sub_res: got %h want FFFE", r); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL sub_err: got %b want 0", err); end
  endtask

  task automatic test_mul();
    logic [15:0] r; int k;
    do_op(3'd3, 8'hFF, 8'hFF, r, k);
    vectors++;
    if (r !== 16'hFE01) begin miscompares++; $display("FAIL mul_res: got %h want FE01", r); end
    vectors++;
    if (k !== MUL_LAT) begin miscompares++; $display("FAIL mul_latency: got %0d want %0d", k, MUL_LAT); end
    do_op(3'd3, 8'hA5, 8'h3C, r, k);
    vectors++;
    if (r !== 16'h26AC) begin miscompares++; $display("FAIL mul2_res: got %h want 26AC", r); end
  endtask

  task automatic test_mac();
    logic [15:0] r; int k;
    do_op(3'd0, 8'h00, 8'h00, r, k);
    vectors++;
    if ({r, ovf} !== {16'h0000, 1'b0}) begin miscompares++; $display("FAIL clr1: got %h/%b want 0000/0", r, ovf); end
    do_op(3'd4, 8'h10, 8'h10, r, k);
    vectors++;
    if (r !== 16'h0100) begin miscompares++; $display("FAIL mac1: got %h want 0100", r); end
    vectors++;
    if (k !== MUL_LAT) begin miscompares++; $display("FAIL mac_latency: got %0d want %0d", k, MUL_LAT); end
    do_op(3'd4, 8'hFF, 8'hFF, r, k);
    vectors++;
    if ({r, ovf} !== {16'hFF01, 1'b0}) begin miscompares++; $display("FAIL mac2: got %h/%b want FF01/0", r, ovf); end
    do_op(3'd4, 8'hFF, 8'hFF, r, k);
    vectors++;
    if ({r, ovf} !== {16'hFD02, 1'b1}) begin miscompares++; $display("FAIL mac3: got %h/%b want FD02/1", r, ovf); end
    do_op(3'd5, 8'h00, 8'h00, r, k);
    vectors++;
    if ({r, ovf} !== {16'hFD02, 1'b1}) begin miscompares++; $display("FAIL rdacc: got %h/%b want FD02/1", r, ovf); end
    do_op(3'd0, 8'h00, 8'h00, r, k);
    vectors++;
    if ({r, ovf} !== {16'h0000, 1'b0}) begin miscompares++; $display("FAIL clr2: got %h/%b want 0000/0", r, ovf); end
  endtask

  task automatic test_backpressure();
    logic [15:0] r; int k;
    res_ready = 1'b0;
    do_op(3'd1, 8'h03, 8'h04, r, k);
    in_valid = 1'b1; op = 3'd1; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({res, res_valid, in_ready} !== {16'h0007, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_%0d: res=%h v=%b rdy=%b want 0007 1 0", i, res, res_valid, in_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({res, res_valid, in_ready} !== {16'h0007, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL release: res=%h v=%b rdy=%b want 0007 0 1", res, res_valid, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal_and_reset();
    logic [15:0] r; int k;
    do_op(3'd4, 8'h20, 8'h03, r, k);
    do_op(3'd6, 8'h11, 8'h22, r, k);
    vectors++;
    if ({r, err} !== {16'h0000, 1'b1}) begin miscompares++; $display("FAIL op6: got %h/%b want 0000/1", r, err); end
    do_op(3'd5, 8'h00, 8'h00, r, k);
    vectors++;
    if ({r, err} !== {16'h0060, 1'b0}) begin miscompares++; $display("FAIL rdacc_kept: got %h/%b want 0060/0", r, err); end
    in_valid = 1'b1; op = 3'd3; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({res, res_valid, in_ready, ovf, err} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_mul_reset: res=%h v=%b rdy=%b ovf=%b err=%b want 0000 0 1 0 0",
               res, res_valid, in_ready, ovf, err);
    end
    @(posedge clk); #1 rst = 1'b0;
    do_op(3'd7, 8'h12, 8'h34, r, k);
    vectors++;
    if ({r, err} !== {16'h0000, 1'b1}) begin miscompares++; $display("FAIL op7: got %h/%b want 0000/1", r, err); end
    do_op(3'd5, 8'h00, 8'h00, r, k);
    vectors++;
    if (r !== 16'h0000) begin miscompares++; $display("FAIL rdacc_after_reset: got %h want 0000", r); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_add();
    test_sub();
    test_mul();
    test_mac();
    test_backpressure();
    test_illegal_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
